// File: rtl/mc_ctrl_fsm.sv
// Main-control FSM for the multicycle RV32I core: decodes opcode/funct3 and sequences the datapath.
// Optional retired-instruction counter is built only when RETIRE_COUNT_EN is defined.
module mc_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = $clog2(MEM_TIMEOUT + 1),
  parameter int RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                adr_src,
  output logic                mem_write,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic [1:0]          src_a,
  output logic [1:0]          src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          result_src,
  output logic                reg_write,
  output logic                fault,
  output logic [1:0]          fault_cause,
  output logic [RETIRE_W-1:0] retired,
  output logic [3:0]          state_dbg
);

  // Memory handshake: a request is outstanding on every cycle mem_req=1; it
  // completes on the cycle mem_ready=1 (transfer happens then). mem_req stays
  // high and address/strobes stay stable until completion or timeout.

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_AUIPC    = 4'd8,
    S_ALUWB    = 4'd9,
    S_LUI      = 4'd10,
    S_BRANCH   = 4'd11,
    S_JAL      = 4'd12,
    S_JALR_TGT = 4'd13,
    S_FAULT    = 4'd14
  } state_t;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  state_t           state_q, state_d;
  logic [TMO_W-1:0] wait_q;
  logic             fault_q;
  logic [1:0]       cause_q, cause_d;
  logic             is_mem, tmo_hit, br_legal, br_take;

  always_comb begin
    is_mem   = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    tmo_hit  = is_mem && !mem_ready && (wait_q == TMO_W'(MEM_TIMEOUT));
    br_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
    br_take  = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
  end

  always_comb begin
    state_d = state_q;
    cause_d = 2'b00;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else if (tmo_hit) begin
          state_d = S_FAULT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (opcode)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECR;
          7'b0010011:             state_d = S_EXECI;
          7'b1100011:             state_d = S_BRANCH;
          7'b1101111:             state_d = S_JAL;
          7'b1100111:             state_d = S_JALR_TGT;
          7'b0110111:             state_d = S_LUI;
          7'b0010111:             state_d = S_AUIPC;
          default: begin
            state_d = S_FAULT;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR:  state_d = (opcode == 7'b0000011) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (mem_ready) state_d = S_MEMWB;
        else if (tmo_hit) begin
          state_d = S_FAULT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_MEMWRITE: begin
        if (mem_ready) state_d = S_FETCH;
        else if (tmo_hit) begin
          state_d = S_FAULT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_MEMWB, S_ALUWB, S_LUI, S_JAL: state_d = S_FETCH;
      S_EXECR, S_EXECI, S_AUIPC:      state_d = S_ALUWB;
      S_BRANCH: begin
        if (br_legal) state_d = S_FETCH;
        else begin
          state_d = S_FAULT;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      // JALR computes rs1+imm into ALUOut, then shares JAL's link/jump step.
      S_JALR_TGT: state_d = S_JAL;
      S_FAULT:    state_d = S_FAULT;
      default: begin
        state_d = S_FAULT;
        cause_d = CAUSE_ILLEGAL;
      end
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    src_a      = 2'b00;
    src_b      = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    reg_write  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        src_b    = 2'b10;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_DECODE: begin
        src_a = 2'b10;
        src_b = 2'b01;
      end
      S_MEMADR, S_JALR_TGT: begin
        src_a = 2'b01;
        src_b = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        src_a  = 2'b01;
        alu_op = 2'b10;
      end
      S_EXECI: begin
        src_a  = 2'b01;
        src_b  = 2'b01;
        alu_op = 2'b10;
      end
      S_AUIPC: begin
        src_a = 2'b10;
        src_b = 2'b01;
      end
      S_ALUWB: reg_write = 1'b1;
      S_LUI: begin
        result_src = 2'b11;
        reg_write  = 1'b1;
      end
      S_BRANCH: begin
        src_a    = 2'b01;
        alu_op   = 2'b01;
        pc_src   = 1'b1;
        pc_write = br_take;
      end
      S_JAL: begin
        src_a      = 2'b10;
        src_b      = 2'b10;
        result_src = 2'b10;
        reg_write  = 1'b1;
        pc_src     = 1'b1;
        pc_write   = 1'b1;
      end
      default: ;
    endcase
    // Held reset forces every strobe and select low, so an abort writes nothing.
    if (!reset) begin
      mem_req    = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      src_a      = 2'b00;
      src_b      = 2'b00;
      alu_op     = 2'b00;
      result_src = 2'b00;
      reg_write  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      fault_q <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      // Staying in a mem state implies no completion and wait_q below the limit.
      if ((state_d != state_q) || mem_ready || !is_mem) wait_q <= '0;
      else                                              wait_q <= wait_q + 1'b1;
      if ((state_d == S_FAULT) && !fault_q) begin
        fault_q <= 1'b1;
        cause_q <= cause_d;
      end
    end
  end

  assign fault       = fault_q;
  assign fault_cause = cause_q;
  assign state_dbg   = state_q;

`ifdef RETIRE_COUNT_EN
  logic                retire_now;
  logic [RETIRE_W-1:0] retired_q;

  always_comb begin
    retire_now = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_LUI) ||
                 (state_q == S_JAL) || ((state_q == S_MEMWRITE) && mem_ready) ||
                 ((state_q == S_BRANCH) && br_legal);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          retired_q <= '0;
    else if (retire_now) retired_q <= retired_q + 1'b1;
  end

  assign retired = retired_q;
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: per-cycle expected control vectors queued by the driver,
// compared by a negedge monitor. Retired-count checks follow RETIRE_COUNT_EN.
module tb_mc_ctrl_fsm;

  localparam int MT = 4;
  localparam int RW = 4;

  localparam int RST = -1, S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3,
                 S_MEMWB = 4, S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7, S_AUIPC = 8,
                 S_ALUWB = 9, S_LUI = 10, S_BRANCH = 11, S_JAL = 12, S_JALR_TGT = 13,
                 S_FAULT = 14;

  localparam int VW = 22;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          zero;
  logic          mem_ready;
  logic          mem_req, adr_src, mem_write, ir_write, pc_write, pc_src, reg_write, fault;
  logic [1:0]    src_a, src_b, alu_op, result_src, fault_cause;
  logic [RW-1:0] retired;
  logic [3:0]    state_dbg;

  logic [VW-1:0] exp_q[$];
  string         lbl_q[$];
  string         cur;
  int            checks = 0;
  int            errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mc_ctrl_fsm #(.MEM_TIMEOUT(MT), .RETIRE_W(RW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .src_a(src_a),
    .src_b(src_b), .alu_op(alu_op), .result_src(result_src), .reg_write(reg_write),
    .fault(fault), .fault_cause(fault_cause), .retired(retired), .state_dbg(state_dbg)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of stimulus, required finish before 200000");
    $fatal(1);
  end

  // Expected control vector for one cycle in a given state, hand-tabulated from the
  // state action list. go = mem_ready in FETCH, branch-taken in BRANCH.
  function automatic logic [VW-1:0] ev(input int st, input bit go, input logic [1:0] cause);
    logic       mr, as, mw, iw, pw, ps, rw, f;
    logic [1:0] sa, sb, ao, rs;
    logic [3:0] s;
    {mr, as, mw, iw, pw, ps, rw, f} = '0;
    {sa, sb, ao, rs} = '0;
    s = (st < 0) ? 4'd0 : st[3:0];
    case (st)
      S_FETCH:    begin mr = 1; sb = 2'b10; iw = go; pw = go; end
      S_DECODE:   begin sa = 2'b10; sb = 2'b01; end
      S_MEMADR:   begin sa = 2'b01; sb = 2'b01; end
      S_MEMREAD:  begin mr = 1; as = 1; end
      S_MEMWB:    begin rs = 2'b01; rw = 1; end
      S_MEMWRITE: begin mr = 1; as = 1; mw = 1; end
      S_EXECR:    begin sa = 2'b01; ao = 2'b10; end
      S_EXECI:    begin sa = 2'b01; sb = 2'b01; ao = 2'b10; end
      S_AUIPC:    begin sa = 2'b10; sb = 2'b01; end
      S_ALUWB:    begin rw = 1; end
      S_LUI:      begin rs = 2'b11; rw = 1; end
      S_BRANCH:   begin sa = 2'b01; ao = 2'b01; ps = 1; pw = go; end
      S_JAL:      begin sa = 2'b10; sb = 2'b10; rs = 2'b10; rw = 1; ps = 1; pw = 1; end
      S_JALR_TGT: begin sa = 2'b01; sb = 2'b01; end
      S_FAULT:    begin f = 1; end
      default: ;
    endcase
    return {s, mr, as, mw, iw, pw, ps, sa, sb, ao, rs, rw, f, cause};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic ins(input logic [6:0] op, input logic [2:0] f3, input logic z, input string name);
    opcode = op;
    funct3 = f3;
    zero   = z;
    cur    = name;
  endtask

  task automatic cyc(input int st, input bit go, input bit rdy, input logic [1:0] cause);
    mem_ready = rdy;
    exp_q.push_back(ev(st, go, cause));
    lbl_q.push_back($sformatf("%s/st%0d", cur, st));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    cur   = "reset";
    repeat (n) cyc(RST, 0, 0, 2'b00);
    reset = 1'b1;
  endtask

  task automatic chk_ret(input logic [RW-1:0] when_enabled, input string name);
    logic [RW-1:0] want;
`ifdef RETIRE_COUNT_EN
    want = when_enabled;
`else
    want = '0;
`endif
    checks++;
    if (retired !== want) begin
      errors++;
      $display("FAIL %s: retired got %0d required %0d", name, retired, want);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [VW-1:0] got, want;
    string         l;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      l    = lbl_q.pop_front();
      got  = {state_dbg, mem_req, adr_src, mem_write, ir_write, pc_write, pc_src,
              src_a, src_b, alu_op, result_src, reg_write, fault, fault_cause};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s @%0t: got %06h required %06h", l, $time, got, want);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; opcode = '0; funct3 = '0; zero = 1'b0; mem_ready = 1'b0; cur = "init";
    @(posedge clk);
    #1;
    do_reset(2);
    chk_ret(4'd0, "ret_after_reset");

    ins(7'b0110011, 3'b000, 0, "add");
    cyc(S_FETCH, 1, 1, 0); cyc(S_DECODE, 0, 1, 0); cyc(S_EXECR, 0, 1, 0); cyc(S_ALUWB, 0, 1, 0);

    ins(7'b0000011, 3'b010, 0, "lw_wait");
    repeat (3) cyc(S_FETCH, 0, 0, 0);
    cyc(S_FETCH, 1, 1, 0); cyc(S_DECODE, 0, 0, 0); cyc(S_MEMADR, 0, 0, 0);
    repeat (2) cyc(S_MEMREAD, 0, 0, 0);
    cyc(S_MEMREAD, 0, 1, 0); cyc(S_MEMWB, 0, 0, 0);

    ins(7'b0100011, 3'b010, 0, "sw");
    cyc(S_FETCH, 1, 1, 0); cyc(S_DECODE, 0, 0, 0); cyc(S_MEMADR, 0, 0, 0); cyc(S_MEMWRITE, 0, 1, 0);

    ins(7'b1100011, 3'b000, 1, "beq_z1");
    cyc(S_FETCH, 1, 1, 0); cyc(S_DECODE, 0, 0, 0); cyc(S_BRANCH, 1, 0, 0);
    ins(7'b1100011, 3'b000, 0, "beq_z0");
    cyc(S_FETCH, 1, 1, 0); cyc(S_DECODE, 0, 0, 0); cyc(S_BRANCH, 0, 0, 0);
    ins(7'b1100011, 3'b001, 0, "bne_z0");
    cyc(S_FETCH, 1, 1, 0); cyc(S_DECODE, 0, 0, 0); cyc(S_BRANCH, 1, 0, 0);
    ins(7'b1100011, 3'b001, 1, "bne_z1");
    cyc(S_FETCH, 1, 1, 0); cyc(S_DECODE, 0, 0, 0); cyc(S_BRANCH, 0, 0, 0);

    ins(7'b1101111, 3'b000, 0, "jal");
    cyc(S_FETCH, 1, 1, 0); cyc(S_DECODE, 0, 0, 0); cyc(S_JAL, 0, 0, 0);
    ins(7'b1100111, 3'b000, 0, "jalr");
    cyc(S_FETCH, 1, 1, 0); cyc(S_DECODE, 0, 0, 0); cyc(S_JALR_TGT, 0, 0, 0); cyc(S_JAL, 0, 0, 0);
    ins(7'b0110111, 3'b000, 0, "lui");
    cyc(S_FETCH, 1, 1, 0); cyc(S_DECODE, 0, 0, 0); cyc(S_LUI, 0, 0, 0);
    ins(7'b0010111, 3'b000, 0, "auipc");
    cyc(S_FETCH, 1, 1, 0); cyc(S_DECODE, 0, 0, 0); cyc(S_AUIPC, 0, 0, 0); cyc(S_ALUWB, 0, 0, 0);
    ins(7'b0010011, 3'b000, 0, "addi");
    cyc(S_FETCH, 1, 1, 0); cyc(S_DECODE, 0, 0, 0); cyc(S_EXECI, 0, 0, 0); cyc(S_ALUWB, 0, 0, 0);

    // Ready arriving on the cycle the wait count equals MEM_TIMEOUT still completes.
    ins(7'b0100011, 3'b010, 0, "sw_edge");
    cyc(S_FETCH, 1, 1, 0); cyc(S_DECODE, 0, 0, 0); cyc(S_MEMADR, 0, 0, 0);
    repeat (MT) cyc(S_MEMWRITE, 0, 0, 0);
    cyc(S_MEMWRITE, 0, 1, 0);
    ins(7'b0110111, 3'b000, 0, "fetch_edge");
    repeat (MT) cyc(S_FETCH, 0, 0, 0);
    cyc(S_FETCH, 1, 1, 0); cyc(S_DECODE, 0, 0, 0); cyc(S_LUI, 0, 0, 0);
    chk_ret(4'd14, "ret_after_mix");

    ins(7'b0110011, 3'b000, 0, "fetch_tmo");
    repeat (MT + 1) cyc(S_FETCH, 0, 0, 0);
    cyc(S_FAULT, 0, 1, 2'b10); cyc(S_FAULT, 0, 0, 2'b10); cyc(S_FAULT, 0, 1, 2'b10);
    do_reset(2);
    chk_ret(4'd0, "ret_after_fault_reset");

    ins(7'b0000011, 3'b010, 0, "lw_tmo");
    cyc(S_FETCH, 1, 1, 0); cyc(S_DECODE, 0, 0, 0); cyc(S_MEMADR, 0, 0, 0);
    repeat (MT + 1) cyc(S_MEMREAD, 0, 0, 0);
    cyc(S_FAULT, 0, 1, 2'b10); cyc(S_FAULT, 0, 0, 2'b10);
    do_reset(1);

    ins(7'b0000000, 3'b000, 0, "illegal_op");
    cyc(S_FETCH, 1, 1, 0); cyc(S_DECODE, 0, 0, 0);
    cyc(S_FAULT, 0, 1, 2'b01); cyc(S_FAULT, 0, 0, 2'b01);
    do_reset(1);

    ins(7'b1100011, 3'b100, 1, "branch_f3_100");
    cyc(S_FETCH, 1, 1, 0); cyc(S_DECODE, 0, 0, 0); cyc(S_BRANCH, 0, 0, 0);
    cyc(S_FAULT, 0, 1, 2'b01); cyc(S_FAULT, 0, 0, 2'b01);
    do_reset(1);

    ins(7'b0110011, 3'b000, 0, "add17");
    repeat (17) begin
      cyc(S_FETCH, 1, 1, 0); cyc(S_DECODE, 0, 0, 0); cyc(S_EXECR, 0, 0, 0); cyc(S_ALUWB, 0, 0, 0);
    end
    chk_ret(4'd1, "ret_wrap_17");

    ins(7'b0110011, 3'b000, 0, "add_abort");
    cyc(S_FETCH, 1, 1, 0); cyc(S_DECODE, 0, 0, 0);
    do_reset(2);
    chk_ret(4'd0, "ret_after_abort");
    ins(7'b0110011, 3'b000, 0, "add_post");
    cyc(S_FETCH, 1, 1, 0); cyc(S_DECODE, 0, 0, 0); cyc(S_EXECR, 0, 0, 0); cyc(S_ALUWB, 0, 0, 0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending vectors required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
